// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one byte-level UART TX core between NUM_REQ requesters.
//            Round-robin by default; fixed priority when UART_TX_ARB_PRIO_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDW      = 2,
    parameter int GAP_CLKS = 434,
    parameter int GAP_W    = 16
) (
    input  logic                   clk_50M,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [GAP_W-1:0] C_GAP_LAST = (GAP_CLKS == 0) ? '0 : GAP_W'(GAP_CLKS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_grant;
    logic                 w_gap_clr;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [NUM_REQ-1:0]   w_cand;
    logic [IDW-1:0]       w_winner;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [7:0]           w_byte;
    logic                 w_any;

`ifndef UART_TX_ARB_PRIO_EN
    logic [IDW-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]   w_above;
`endif

    // Winner = lowest-index candidate; round-robin restricts candidates to
    // those above the last grant when any exist, which gives the wrap order.
    always_comb begin
        w_winner = '0;
        w_onehot = '0;
        w_byte   = '0;
        w_any    = |req_valid;
`ifndef UART_TX_ARB_PRIO_EN
        w_above  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_above[i] = req_valid[i] && (i > int'(r_last_grant));
        end
        w_cand = (|w_above) ? w_above : req_valid;
`else
        w_cand = req_valid;
`endif
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winner = IDW'(i);
                w_onehot = NUM_REQ'(1) << i;
                w_byte   = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_gap_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    w_next  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_gap_clr = 1'b1;
                    w_next    = (GAP_CLKS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            grant_id     <= '0;
            r_gap_cnt    <= '0;
`ifndef UART_TX_ARB_PRIO_EN
            r_last_grant <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            tx_start  <= w_grant;
            req_ready <= w_grant ? w_onehot : '0;
            if (w_grant) begin
                tx_data      <= w_byte;
                grant_id     <= w_winner;
`ifndef UART_TX_ARB_PRIO_EN
                r_last_grant <= w_winner;
`endif
            end
            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire
